fft_pair_feeder: RTL
====================

FFT_PAIR_FEEDER -- requirements
Module: fft_pair_feeder

Interface
REQ-001 SHALL have parameter N, default 64: FFT size, a power of two, 4..1024.
REQ-002 SHALL have parameter SCALE, default 1: when 1, each output component is arithmetic-shifted right by 1; when 0, it passes unscaled.
REQ-003 SHALL have port clock, input, 1: single rising-edge clock for all state.
REQ-004 SHALL have port resetn, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port clear, input, 1: synchronous frame restart.
REQ-006 SHALL have port in_valid, input, 1: an input sample is present.
REQ-007 SHALL have port in_ready, output, 1: the block accepts a sample this cycle.
REQ-008 SHALL have port in_x, input, 16 signed: real part of the input sample.
REQ-009 SHALL have port in_y, input, 16 signed: imaginary part of the input sample.
REQ-010 SHALL have port out_valid, output, 1: the output pair is valid.
REQ-011 SHALL have port out_ready, input, 1: the downstream butterfly consumes the pair.
REQ-012 SHALL have ports xout1/yout1, outputs, 16 signed each: sample k of the pair.
REQ-013 SHALL have ports xout2/yout2, outputs, 16 signed each: sample k+N/2 of the pair.
REQ-014 SHALL have port zangle, output, 32 signed: twiddle rotation for the pair.
REQ-015 SHALL have port out_last, output, 1: marks pair k = N/2-1, the last pair of the frame.

Function
REQ-016 SHALL accept a sample only on a cycle where in_valid and in_ready are both 1.
REQ-017 SHALL implement two states: FILL and PAIR, each with index counter k of width log2(N/2).
REQ-018 In FILL, SHALL write each accepted sample to buffer[k] and increment k; on acceptance with k = N/2-1, SHALL set k to 0 and go to PAIR.
REQ-019 In PAIR, SHALL pair each accepted sample (the k+N/2 sample) with buffer[k] and load the output register on that edge, so out_valid is 1 one cycle after acceptance.
REQ-020 In PAIR, on acceptance with k = N/2-1, SHALL set k to 0 and go to FILL; the next frame's FILL SHALL overlap the draining of the last pair.
REQ-021 SHALL drive zangle = -(k * 2^32 / N) mod 2^32, where a full scale of 2^32 equals 2π (DIF twiddle e^-j2πk/N); for k = 0, zangle SHALL be 0.
REQ-022 With SCALE = 1, SHALL output xout = x >>> 1, with the same rule per component, so that the butterfly's 16-bit add/subtract cannot overflow.
REQ-023 SHALL set out_last to 1 together with the output pair for k = N/2-1, and to 0 otherwise.
REQ-024 SHALL hold out_valid and all output values stable while out_valid = 1 and out_ready = 0.
REQ-025 SHALL clear out_valid after an edge with out_valid & out_ready, unless a new pair is loaded on that same edge.
REQ-026 SHALL drive in_ready = (state == FILL) | !out_valid | out_ready, combinationally.
REQ-027 On a simultaneous output consume and PAIR acceptance, SHALL load the new pair with no bubble, giving one pair per clock at full throughput.
REQ-028 On clear = 1, SHALL set state to FILL, set k to 0 and out_valid to 0, and SHALL ignore any input in that cycle; buffer contents need not be reset.
REQ-029 SHALL stall without loss under any in_valid/out_ready pattern; input order SHALL map exactly to the pair order.

Reset
REQ-030 With resetn = 0, SHALL immediately force state = FILL, k = 0, out_valid = 0, out_last = 0, all data outputs = 0 and zangle = 0.
REQ-031 After resetn rises, SHALL show in_ready = 1.
REQ-032 A reset asserted mid-frame SHALL discard the partial frame; the first sample after reset SHALL be sample 0 of a new frame.

Verification
REQ-033 Bench SHALL cover: N=8, SCALE=0, 8 samples (x=i, y=-i) streamed back-to-back with out_ready=1 -> 4 pairs (0,4),(1,5),(2,6),(3,7) on consecutive cycles, zangle = 0, 0xE0000000, 0xC0000000, 0xA0000000, and out_last only on the 4th pair.
REQ-034 Bench SHALL cover: the same stream with out_ready=0 for 5 cycles after the first pair -> the pair stays held and in_ready=0 in PAIR; after release, all pairs arrive intact and in order.
REQ-035 Bench SHALL cover: SCALE=1 with input x=-32768 and -1 -> xout = -16384 and -1, respectively (floor shift).
REQ-036 Bench SHALL cover: resetn pulled low after 6 accepted samples -> out_valid=0 at once; a fresh 8-sample frame then yields pairs (0,4)..(3,7) of the new data.
REQ-037 Bench SHALL cover: clear asserted on the cycle sample 5 is offered -> sample 5 is not accepted and state returns to FILL with k=0.
REQ-038 Bench SHALL cover: two frames streamed continuously with random in_valid/out_ready -> 8 pairs match the reference model and out_last appears exactly twice.

Source files
------------

// File: rtl/fft_pair_feeder.sv
// Radix-2 DIF front end: buffers the first half of each frame, then pairs
// every second-half sample k+N/2 with buffered sample k and presents the pair
// with its twiddle angle to a downstream butterfly over a valid/ready handshake.
module fft_pair_feeder #(
    parameter int N     = 64,
    parameter int SCALE = 1
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [15:0] in_x,
    input  logic signed [15:0] in_y,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [15:0] xout1,
    output logic signed [15:0] yout1,
    output logic signed [15:0] xout2,
    output logic signed [15:0] yout2,
    output logic signed [31:0] zangle,
    output logic               out_last
);
    localparam int LOGN = $clog2(N);
    localparam int KW   = LOGN - 1;
    localparam int HALF = N / 2;
    localparam logic [KW-1:0] K_LAST = KW'(HALF - 1);

    typedef enum logic {FILL, PAIR} state_t;

    state_t             state_q, state_d;
    logic [KW-1:0]      k_q, k_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic signed [15:0] x1_q, x1_d, y1_q, y1_d, x2_q, x2_d, y2_q, y2_d;
    logic signed [31:0] za_q, za_d;
    logic signed [15:0] buf_x [HALF];
    logic signed [15:0] buf_y [HALF];
    logic               accept;
    logic               buf_we;
    logic [31:0]        ang;

    // Halving each component keeps the butterfly's 16-bit sum/difference in range.
    function automatic logic signed [15:0] scale_c(input logic signed [15:0] v);
        if (SCALE != 0) return v >>> 1;
        return v;
    endfunction

    // FILL always has room; PAIR needs the output register free or draining.
    assign in_ready = (state_q == FILL) | ~out_valid_q | out_ready;
    assign accept   = in_valid & in_ready & ~clear;

    // k * 2^32 / N, i.e. k placed so that N steps span the full 2^32 circle.
    assign ang = {{(32 - KW){1'b0}}, k_q} << (32 - LOGN);

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign xout1     = x1_q;
    assign yout1     = y1_q;
    assign xout2     = x2_q;
    assign yout2     = y2_q;
    assign zangle    = za_q;

    // Next-state, index and output-register loading for the FILL/PAIR machine.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        x1_d        = x1_q;
        y1_d        = y1_q;
        x2_d        = x2_q;
        y2_d        = y2_q;
        za_d        = za_q;
        buf_we      = 1'b0;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (clear) begin
            state_d     = FILL;
            k_d         = '0;
            out_valid_d = 1'b0;
        end else if (accept) begin
            k_d = (k_q == K_LAST) ? '0 : k_q + KW'(1);
            if (state_q == FILL) begin
                buf_we = 1'b1;
                if (k_q == K_LAST) state_d = PAIR;
            end else begin
                // A load here overrides the consume-clear above: no bubble.
                out_valid_d = 1'b1;
                x1_d        = scale_c(buf_x[k_q]);
                y1_d        = scale_c(buf_y[k_q]);
                x2_d        = scale_c(in_x);
                y2_d        = scale_c(in_y);
                za_d        = -$signed(ang);
                out_last_d  = (k_q == K_LAST);
                if (k_q == K_LAST) state_d = FILL;
            end
        end
    end

    // Control and output registers; reset clears everything visible.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= FILL;
            k_q         <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            x1_q        <= '0;
            y1_q        <= '0;
            x2_q        <= '0;
            y2_q        <= '0;
            za_q        <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            x1_q        <= x1_d;
            y1_q        <= y1_d;
            x2_q        <= x2_d;
            y2_q        <= y2_d;
            za_q        <= za_d;
        end
    end

    // First-half sample store; stale contents are never read before rewrite.
    always_ff @(posedge clock) begin
        if (buf_we) begin
            buf_x[k_q] <= in_x;
            buf_y[k_q] <= in_y;
        end
    end

endmodule
